// File: rtl/gsensor_spi_responder.sv
// SPI mode-3 responder that emulates an ADXL345-style G-sensor register map.
// X/Y/Z samples are injected from the fabric; reads within one frame see a coherent shadow copy.
module gsensor_spi_responder #(
    parameter logic [7:0] DEVID    = 8'hE5,
    parameter logic [7:0] BW_RESET = 8'h0A
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        sdi,
    output logic        sdo,
    output logic        sdo_oe,
    input  logic [15:0] x_in,
    input  logic [15:0] y_in,
    input  logic [15:0] z_in,
    input  logic        sample_valid,
    output logic [1:0]  int_out,
    output logic        reg_wr_strobe,
    output logic [5:0]  reg_wr_addr,
    output logic [7:0]  reg_wr_data,
    output logic        busy
);

    localparam logic [5:0] A_DEVID      = 6'h00;
    localparam logic [5:0] A_BW_RATE    = 6'h2C;
    localparam logic [5:0] A_INT_ENABLE = 6'h2E;
    localparam logic [5:0] A_INT_MAP    = 6'h2F;
    localparam logic [5:0] A_INT_SOURCE = 6'h30;
    localparam logic [5:0] A_DATAX0     = 6'h32;
    localparam logic [5:0] A_DATAZ1     = 6'h37;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_RD,
        S_WR
    } state_t;

    // Synchronisers and edge detection
    logic [2:0] r_sclk_sync;
    logic [2:0] r_cs_sync;
    logic [1:0] r_sdi_sync;
    logic       r_busy;

    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_cs_fall;
    logic w_cs_rise;
    logic w_sdi;

    // FSM and shift path
    state_t     r_state;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_rx_shift;
    logic [7:0] r_tx_shift;
    logic [5:0] r_addr;
    logic       r_mb;
    logic       r_frame_rd_data;
    logic       r_sdo;
    logic       r_sdo_oe;
    logic       r_wr_strobe;
    logic [5:0] r_wr_addr;
    logic [7:0] r_wr_data;

    // Register file and sample path
    logic [7:0]  r_regs [64];
    logic [15:0] r_live_x;
    logic [15:0] r_live_y;
    logic [15:0] r_live_z;
    logic [15:0] r_shadow_x;
    logic [15:0] r_shadow_y;
    logic [15:0] r_shadow_z;
    logic        r_data_ready;
    logic [1:0]  r_int_out;

    logic [5:0] w_cmd_addr;
    logic [5:0] w_next_addr;
    logic       w_addr_is_data;
    logic [7:0] w_cmd_rd_data;
    logic [7:0] w_next_rd_data;
    logic       w_dr_int;

    function automatic logic f_writable(input logic [5:0] a);
        return (a >= 6'h1D && a <= 6'h2A) || (a >= A_BW_RATE && a <= A_INT_MAP) ||
               (a == 6'h31) || (a == 6'h38);
    endfunction

    function automatic logic [7:0] f_reg_read(input logic [5:0] a);
        logic [7:0] v;
        // NOTE: give every combinational result a default first so no path leaves it unassigned (latch).
        v = 8'h00;
        case (a)
            A_DEVID:      v = DEVID;
            A_INT_SOURCE: v = {r_data_ready, 7'b0};
            6'h32:        v = r_shadow_x[7:0];
            6'h33:        v = r_shadow_x[15:8];
            6'h34:        v = r_shadow_y[7:0];
            6'h35:        v = r_shadow_y[15:8];
            6'h36:        v = r_shadow_z[7:0];
            6'h37:        v = r_shadow_z[15:8];
            default:      if (f_writable(a)) v = r_regs[a];
        endcase
        return v;
    endfunction

    assign w_sclk_rise    = r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_sclk_fall    = ~r_sclk_sync[1] & r_sclk_sync[2];
    assign w_cs_fall      = ~r_cs_sync[1] & r_cs_sync[2];
    assign w_cs_rise      = r_cs_sync[1] & ~r_cs_sync[2];
    assign w_sdi          = r_sdi_sync[1];

    assign w_cmd_addr     = {r_rx_shift[4:0], w_sdi};
    assign w_next_addr    = r_mb ? r_addr + 6'd1 : r_addr;
    assign w_addr_is_data = (r_addr >= A_DATAX0) && (r_addr <= A_DATAZ1);
    assign w_cmd_rd_data  = f_reg_read(w_cmd_addr);
    assign w_next_rd_data = f_reg_read(w_next_addr);
    assign w_dr_int       = r_data_ready & r_regs[A_INT_ENABLE][7];

    // cs_n chain resets to "selected" so a cs_n still low after reset never looks like a fresh frame start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_sync <= 3'b111;
            r_cs_sync   <= 3'b000;
            r_sdi_sync  <= 2'b00;
            r_busy      <= 1'b0;
        end else begin
            // NOTE: sequential state always uses non-blocking assignments so every flop sees pre-edge values.
            r_sclk_sync <= {r_sclk_sync[1:0], sclk};
            r_cs_sync   <= {r_cs_sync[1:0], cs_n};
            r_sdi_sync  <= {r_sdi_sync[0], sdi};
            r_busy      <= ~r_cs_sync[1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= S_IDLE;
            r_bit_cnt       <= 3'd0;
            r_rx_shift      <= 7'd0;
            r_tx_shift      <= 8'd0;
            r_addr          <= 6'd0;
            r_mb            <= 1'b0;
            r_frame_rd_data <= 1'b0;
            r_sdo           <= 1'b0;
            r_sdo_oe        <= 1'b0;
            r_wr_strobe     <= 1'b0;
            r_wr_addr       <= 6'd0;
            r_wr_data       <= 8'd0;
        end else begin
            r_wr_strobe <= 1'b0;
            if (w_cs_rise) begin
                r_state   <= S_IDLE;
                r_bit_cnt <= 3'd0;
                r_sdo     <= 1'b0;
                r_sdo_oe  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_cs_fall) begin
                            r_state         <= S_CMD;
                            r_bit_cnt       <= 3'd0;
                            r_frame_rd_data <= 1'b0;
                        end
                    end
                    S_CMD: begin
                        if (w_sclk_rise) begin
                            r_rx_shift <= {r_rx_shift[5:0], w_sdi};
                            r_bit_cnt  <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_mb   <= r_rx_shift[5];
                                r_addr <= w_cmd_addr;
                                if (r_rx_shift[6]) begin
                                    r_state    <= S_RD;
                                    r_tx_shift <= w_cmd_rd_data;
                                end else begin
                                    r_state <= S_WR;
                                end
                            end
                        end
                    end
                    S_RD: begin
                        // Next byte is preloaded on the last rising edge so bit7 is ready for the following fall.
                        if (w_sclk_fall) begin
                            r_sdo      <= r_tx_shift[7];
                            r_sdo_oe   <= 1'b1;
                            r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                        end else if (w_sclk_rise) begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                if (w_addr_is_data) r_frame_rd_data <= 1'b1;
                                r_addr     <= w_next_addr;
                                r_tx_shift <= w_next_rd_data;
                            end
                        end
                    end
                    S_WR: begin
                        if (w_sclk_rise) begin
                            r_rx_shift <= {r_rx_shift[5:0], w_sdi};
                            r_bit_cnt  <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_wr_strobe <= 1'b1;
                                r_wr_addr   <= r_addr;
                                r_wr_data   <= {r_rx_shift, w_sdi};
                                r_addr      <= w_next_addr;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the register file is tiny and architecturally visible, so it is reset like any other flop.
            for (int i = 0; i < 64; i++) begin
                r_regs[6'(i)] <= (6'(i) == A_BW_RATE) ? BW_RESET : 8'h00;
            end
            r_live_x     <= 16'd0;
            r_live_y     <= 16'd0;
            r_live_z     <= 16'd0;
            r_shadow_x   <= 16'd0;
            r_shadow_y   <= 16'd0;
            r_shadow_z   <= 16'd0;
            r_data_ready <= 1'b0;
            r_int_out    <= 2'b00;
        end else begin
            if (r_wr_strobe && f_writable(r_wr_addr)) r_regs[r_wr_addr] <= r_wr_data;
            if (sample_valid) begin
                r_live_x <= x_in;
                r_live_y <= y_in;
                r_live_z <= z_in;
            end
            if (w_cs_fall) begin
                r_shadow_x <= r_live_x;
                r_shadow_y <= r_live_y;
                r_shadow_z <= r_live_z;
            end
            if (sample_valid)                        r_data_ready <= 1'b1;
            else if (w_cs_rise && r_frame_rd_data)   r_data_ready <= 1'b0;
            r_int_out <= r_regs[A_INT_MAP][7] ? {w_dr_int, 1'b0} : {1'b0, w_dr_int};
        end
    end

    assign sdo           = r_sdo;
    assign sdo_oe        = r_sdo_oe;
    assign int_out       = r_int_out;
    assign reg_wr_strobe = r_wr_strobe;
    assign reg_wr_addr   = r_wr_addr;
    assign reg_wr_data   = r_wr_data;
    assign busy          = r_busy;

endmodule
